// File: rtl/pr_stream_decoupler.sv
// Packet-aware isolation between the static shell and a reconfigurable partition.
// Each stream channel is cut only at a packet boundary unless the drain timeout forces a cut.
module pr_stream_decoupler #(
  parameter int                NUM_CH      = 4,
  parameter int                DATA_W      = 512,
  parameter int                KEEP_W      = 16,
  parameter int                USER_W      = 183,
  parameter logic [NUM_CH-1:0] RP_SRC_MASK = 4'b0011,
  parameter int unsigned       TIMEOUT_CYC = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       decouple_req,
  output logic                       decouple_ack,
  output logic                       timeout_err,
  input  logic [NUM_CH*DATA_W-1:0]   s_tdata,
  input  logic [NUM_CH*KEEP_W-1:0]   s_tkeep,
  input  logic [NUM_CH*USER_W-1:0]   s_tuser,
  input  logic [NUM_CH-1:0]          s_tlast,
  input  logic [NUM_CH-1:0]          s_tvalid,
  output logic [NUM_CH-1:0]          s_tready,
  output logic [NUM_CH*DATA_W-1:0]   m_tdata,
  output logic [NUM_CH*KEEP_W-1:0]   m_tkeep,
  output logic [NUM_CH*USER_W-1:0]   m_tuser,
  output logic [NUM_CH-1:0]          m_tlast,
  output logic [NUM_CH-1:0]          m_tvalid,
  input  logic [NUM_CH-1:0]          m_tready
);

  typedef enum logic [1:0] {COUPLED, DRAINING, FLUSH, DECOUPLED} state_t;

  localparam bit          TO_EN   = (TIMEOUT_CYC != 0);
  localparam logic [31:0] TO_LAST = TIMEOUT_CYC - 1;

  state_t            state;
  logic [NUM_CH-1:0] gate;
  logic [NUM_CH-1:0] discard;
  logic [NUM_CH-1:0] pending_flush;
  logic [NUM_CH-1:0] in_pkt;
  logic [31:0]       drain_cnt;

  logic [NUM_CH-1:0] accept;
  logic [NUM_CH-1:0] flush_taken;
  logic [NUM_CH-1:0] flush_left;
  logic [NUM_CH-1:0] in_pkt_next;
  logic [NUM_CH-1:0] discard_keep;
  logic [NUM_CH-1:0] rp_cut;
  logic [NUM_CH-1:0] shell_cut;
  logic [NUM_CH-1:0] pass;
  logic              timeout_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign pass[gi] = ~gate[gi] & ~discard[gi] & ~pending_flush[gi];

      // A pending flush owns the output: an empty tlast beat closes the shell-side packet.
      assign m_tvalid[gi] = pending_flush[gi] | (pass[gi] & s_tvalid[gi]);
      assign m_tlast[gi]  = pending_flush[gi] | (pass[gi] & s_tlast[gi]);
      assign m_tdata[gi*DATA_W +: DATA_W] = pass[gi] ? s_tdata[gi*DATA_W +: DATA_W] : '0;
      assign m_tkeep[gi*KEEP_W +: KEEP_W] = pass[gi] ? s_tkeep[gi*KEEP_W +: KEEP_W] : '0;
      assign m_tuser[gi*USER_W +: USER_W] = pass[gi] ? s_tuser[gi*USER_W +: USER_W] : '0;
      assign s_tready[gi] = ~pending_flush[gi] & (discard[gi] | (~gate[gi] & m_tready[gi]));

      assign accept[gi]       = s_tvalid[gi] & s_tready[gi];
      assign flush_taken[gi]  = pending_flush[gi] & m_tready[gi];
      assign flush_left[gi]   = pending_flush[gi] & ~m_tready[gi];
      assign in_pkt_next[gi]  = flush_taken[gi] ? 1'b0 : (accept[gi] ? ~s_tlast[gi] : in_pkt[gi]);
      assign discard_keep[gi] = discard[gi] & ~(accept[gi] & s_tlast[gi]);
    end
  endgenerate

  assign rp_cut      = ~gate & in_pkt_next & RP_SRC_MASK;
  assign shell_cut   = ~gate & in_pkt_next & ~RP_SRC_MASK;
  assign timeout_hit = TO_EN && (drain_cnt == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= COUPLED;
      gate          <= '0;
      discard       <= '0;
      pending_flush <= '0;
      in_pkt        <= '0;
      drain_cnt     <= '0;
      decouple_ack  <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      in_pkt  <= in_pkt_next;
      discard <= discard_keep;
      case (state)
        COUPLED: begin
          if (decouple_req) begin
            state       <= DRAINING;
            drain_cnt   <= '0;
            timeout_err <= 1'b0;
          end
        end
        DRAINING: begin
          if (!decouple_req) begin
            state <= COUPLED;
            gate  <= '0;
          end else if (&gate) begin
            state        <= DECOUPLED;
            in_pkt       <= '0;
            decouple_ack <= 1'b1;
          end else if (timeout_hit) begin
            // RP-driven packets get a synthetic tail; shell-driven ones are swallowed.
            timeout_err   <= 1'b1;
            gate          <= gate | ~in_pkt_next | ~RP_SRC_MASK;
            discard       <= discard_keep | shell_cut;
            pending_flush <= rp_cut;
            if (|rp_cut) begin
              state <= FLUSH;
            end else begin
              state        <= DECOUPLED;
              in_pkt       <= '0;
              decouple_ack <= 1'b1;
            end
          end else begin
            gate <= gate | ~in_pkt_next;
            if (~&drain_cnt) drain_cnt <= drain_cnt + 32'd1;
          end
        end
        FLUSH: begin
          pending_flush <= flush_left;
          gate          <= gate | flush_taken;
          if (flush_left == '0) begin
            if (decouple_req) begin
              state        <= DECOUPLED;
              in_pkt       <= '0;
              decouple_ack <= 1'b1;
            end else begin
              state <= COUPLED;
              gate  <= '0;
            end
          end
        end
        default: begin
          if (!decouple_req) begin
            state        <= COUPLED;
            gate         <= '0;
            decouple_ack <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pr_stream_decoupler.sv
// Bench for pr_stream_decoupler: directed scenarios plus randomized traffic,
// every cycle compared against a channel-status reference model.
module tb_pr_stream_decoupler;
  localparam int NC = 4, DW = 32, KW = 4, UW = 8, TO = 16;

  logic clk = 1'b0;
  logic rst, decouple_req, decouple_ack, timeout_err;
  logic [NC*DW-1:0] s_tdata, m_tdata;
  logic [NC*KW-1:0] s_tkeep, m_tkeep;
  logic [NC*UW-1:0] s_tuser, m_tuser;
  logic [NC-1:0]    s_tlast, s_tvalid, s_tready, m_tlast, m_tvalid, m_tready;
  logic [NC-1:0]    rp_mask = 4'b0011;

  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  pr_stream_decoupler #(
    .NUM_CH(NC), .DATA_W(DW), .KEEP_W(KW), .USER_W(UW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst), .decouple_req(decouple_req), .decouple_ack(decouple_ack),
    .timeout_err(timeout_err),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tuser(s_tuser), .s_tlast(s_tlast),
    .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tuser(m_tuser), .m_tlast(m_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: phase 0 coupled, 1 draining, 2 flushing, 3 decoupled.
  int  phase, waited;
  bit  blk[NC], drp[NC], trm[NC], opn[NC];
  bit  ack_m, err_m;
  logic [NC-1:0]    e_mv, e_ml, e_sr;
  logic [NC*DW-1:0] e_md;
  logic [NC*KW-1:0] e_mk;
  logic [NC*UW-1:0] e_mu;

  task automatic model_reset();
    phase = 0; waited = 0; ack_m = 0; err_m = 0;
    for (int c = 0; c < NC; c++) begin
      blk[c] = 0; drp[c] = 0; trm[c] = 0; opn[c] = 0;
    end
  endtask

  task automatic model_outputs();
    e_mv = '0; e_ml = '0; e_sr = '0; e_md = '0; e_mk = '0; e_mu = '0;
    for (int c = 0; c < NC; c++) begin
      if (trm[c]) begin
        e_mv[c] = 1'b1; e_ml[c] = 1'b1;
      end else if (drp[c]) begin
        e_sr[c] = 1'b1;
      end else if (!blk[c]) begin
        e_mv[c] = s_tvalid[c]; e_ml[c] = s_tlast[c]; e_sr[c] = m_tready[c];
        e_md[c*DW +: DW] = s_tdata[c*DW +: DW];
        e_mk[c*KW +: KW] = s_tkeep[c*KW +: KW];
        e_mu[c*UW +: UW] = s_tuser[c*UW +: UW];
      end
    end
  endtask

  task automatic model_step();
    bit nopen[NC];
    bit tk[NC];
    bit acc, all_blk, any_trm, tmo;
    if (rst) begin
      model_reset();
      return;
    end
    model_outputs();
    all_blk = 1;
    for (int c = 0; c < NC; c++) if (!blk[c]) all_blk = 0;
    for (int c = 0; c < NC; c++) begin
      tk[c]    = trm[c] && m_tready[c];
      acc      = s_tvalid[c] && e_sr[c];
      nopen[c] = tk[c] ? 1'b0 : (acc ? !s_tlast[c] : opn[c]);
      if (acc && s_tlast[c]) drp[c] = 0;
      opn[c] = nopen[c];
    end
    case (phase)
      0: if (decouple_req) begin phase = 1; waited = 0; err_m = 0; end
      1: begin
        if (!decouple_req) begin
          phase = 0;
          for (int c = 0; c < NC; c++) blk[c] = 0;
        end else if (all_blk) begin
          phase = 3;
          for (int c = 0; c < NC; c++) opn[c] = 0;
        end else begin
          tmo = (waited == TO - 1);
          any_trm = 0;
          for (int c = 0; c < NC; c++) begin
            if (!blk[c]) begin
              if (!nopen[c]) blk[c] = 1;
              else if (tmo) begin
                if (rp_mask[c]) trm[c] = 1;
                else begin blk[c] = 1; drp[c] = 1; end
              end
            end
            if (trm[c]) any_trm = 1;
          end
          if (tmo) begin
            err_m = 1;
            phase = any_trm ? 2 : 3;
            if (phase == 3) for (int c = 0; c < NC; c++) opn[c] = 0;
          end else begin
            waited++;
          end
        end
      end
      2: begin
        any_trm = 0;
        for (int c = 0; c < NC; c++) begin
          if (tk[c]) begin trm[c] = 0; blk[c] = 1; end
          if (trm[c]) any_trm = 1;
        end
        if (!any_trm) begin
          if (decouple_req) begin
            phase = 3;
            for (int c = 0; c < NC; c++) opn[c] = 0;
          end else begin
            phase = 0;
            for (int c = 0; c < NC; c++) blk[c] = 0;
          end
        end
      end
      default: if (!decouple_req) begin
        phase = 0;
        for (int c = 0; c < NC; c++) blk[c] = 0;
      end
    endcase
    ack_m = (phase == 3);
  endtask

  // Compare the whole DUT against the model, advance the model, move to the next negedge.
  task automatic cycle();
    #1;
    model_outputs();
    check("ack", decouple_ack, ack_m);
    check("err", timeout_err, err_m);
    check("m_tvalid", m_tvalid, e_mv);
    check("m_tlast", m_tlast, e_ml);
    check("s_tready", s_tready, e_sr);
    check("m_tdata", m_tdata, e_md);
    check("m_tkeep", m_tkeep, e_mk);
    check("m_tuser", m_tuser, e_mu);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    s_tvalid = '0; s_tlast = '0; m_tready = '1;
    for (int c = 0; c < NC; c++) begin
      s_tdata[c*DW +: DW] = $urandom;
      s_tkeep[c*KW +: KW] = KW'($urandom);
      s_tuser[c*UW +: UW] = UW'($urandom);
    end
  endtask

  task automatic beat(input int c, input bit last);
    s_tvalid[c] = 1'b1;
    s_tlast[c]  = last;
    s_tdata[c*DW +: DW] = $urandom | 32'h1;
    s_tkeep[c*KW +: KW] = KW'($urandom);
    s_tuser[c*UW +: UW] = UW'($urandom);
  endtask

  initial begin
    logic [NC-1:0] active;
    rst = 1'b1; decouple_req = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    s_tvalid = '1; s_tlast = '1; m_tready = 4'hA;
    #1;
    check("rst_ack", decouple_ack, 0);
    check("rst_err", timeout_err, 0);
    check("rst_sready", s_tready, 4'hA);
    check("rst_mvalid", m_tvalid, 4'hF);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    cycle();

    // All channels idle (every beat a single-beat packet).
    s_tvalid = '1; s_tlast = '1; decouple_req = 1'b1;
    cycle();
    check("s1_e0_pass", s_tready, 4'hF);
    check("s1_e0_ack", decouple_ack, 0);
    cycle();
    check("s1_e1_sready", s_tready, 4'h0);
    check("s1_e1_mvalid", m_tvalid, 4'h0);
    check("s1_e1_ack", decouple_ack, 0);
    cycle();
    check("s1_e2_ack", decouple_ack, 1);
    decouple_req = 1'b0;
    cycle();
    check("s1_rel_ack", decouple_ack, 0);
    check("s1_rel_sready", s_tready, 4'hF);
    check("s1_rel_mvalid", m_tvalid, 4'hF);
    $display("[TB] scenario idle_decouple done");

    // Channel 0 mid-packet finishes before it gates.
    idle_inputs(); beat(0, 0); cycle();
    decouple_req = 1'b1; beat(0, 0); cycle();
    beat(0, 0); cycle();
    check("s2_e1_sready", s_tready, 4'b0001);
    beat(0, 1); #1;
    check("s2_last_mvalid", m_tvalid, 4'b0001);
    check("s2_last_mtlast", m_tlast, 4'b0001);
    cycle();
    check("s2_gate_ack", decouple_ack, 0);
    idle_inputs(); cycle();
    check("s2_ack", decouple_ack, 1);
    decouple_req = 1'b0; cycle();
    check("s2_rel_ack", decouple_ack, 0);
    $display("[TB] scenario drain_ch0 done");

    // RP channel 1 stalls mid-packet: timeout then flush beat held under backpressure.
    idle_inputs(); beat(1, 0); cycle();
    idle_inputs(); m_tready[1] = 1'b0; decouple_req = 1'b1;
    repeat (16) cycle();
    check("s3_preflush", m_tvalid, 4'h0);
    cycle();
    check("s3_flush_mvalid", m_tvalid, 4'b0010);
    check("s3_flush_mtlast", m_tlast, 4'b0010);
    check("s3_flush_mtdata", m_tdata, 0);
    check("s3_flush_mtkeep", m_tkeep, 0);
    check("s3_flush_err", timeout_err, 1);
    check("s3_flush_ack", decouple_ack, 0);
    repeat (4) begin
      cycle();
      check("s3_hold", m_tvalid, 4'b0010);
    end
    m_tready[1] = 1'b1; cycle();
    check("s3_ack", decouple_ack, 1);
    check("s3_err", timeout_err, 1);
    decouple_req = 1'b0; cycle();
    check("s3_rel_ack", decouple_ack, 0);
    check("s3_err_sticky", timeout_err, 1);
    $display("[TB] scenario rp_flush done");

    // Shell channel 2 stalls mid-packet: remainder is discarded after the timeout.
    idle_inputs(); beat(2, 0); cycle();
    idle_inputs(); decouple_req = 1'b1;
    repeat (17) cycle();
    check("s4_ack", decouple_ack, 1);
    check("s4_err", timeout_err, 1);
    for (int i = 0; i < 3; i++) begin
      idle_inputs(); beat(2, i == 2); #1;
      check("s4_drop_sready", s_tready[2], 1);
      check("s4_drop_mvalid", m_tvalid, 4'h0);
      cycle();
    end
    idle_inputs(); beat(2, 0); #1;
    check("s4_after_drop", s_tready, 4'h0);
    cycle();
    idle_inputs(); decouple_req = 1'b0; cycle();
    check("s4_rel_ack", decouple_ack, 0);
    $display("[TB] scenario shell_discard done");

    // Request withdrawn while draining.
    idle_inputs(); beat(0, 0); cycle();
    decouple_req = 1'b1; beat(0, 0); cycle();
    decouple_req = 1'b0; beat(0, 0); cycle();
    check("s5_sready", s_tready, 4'hF);
    check("s5_ack", decouple_ack, 0);
    beat(0, 1); #1;
    check("s5_last_mvalid", m_tvalid, 4'b0001);
    check("s5_last_data", m_tdata[DW-1:0], s_tdata[DW-1:0]);
    cycle();
    idle_inputs(); cycle();
    check("s5_end_ack", decouple_ack, 0);
    check("s5_end_err", timeout_err, 0);
    $display("[TB] scenario abort_drain done");

    // Asynchronous reset while a flush beat is pending.
    idle_inputs(); beat(0, 0); cycle();
    idle_inputs(); m_tready[0] = 1'b0; decouple_req = 1'b1;
    repeat (17) cycle();
    check("s6_flush", m_tvalid, 4'b0001);
    #1; rst = 1'b1; model_reset();
    m_tready = '1; s_tvalid[0] = 1'b1; s_tlast[0] = 1'b0; s_tdata[DW-1:0] = 32'hA5A5_0001;
    #1;
    check("s6_rst_data", m_tdata[DW-1:0], 32'hA5A5_0001);
    check("s6_rst_mtlast", m_tlast[0], 0);
    check("s6_rst_sready", s_tready, 4'hF);
    check("s6_rst_ack", decouple_ack, 0);
    check("s6_rst_err", timeout_err, 0);
    cycle();
    rst = 1'b0; decouple_req = 1'b0; idle_inputs(); cycle();
    check("s6_post_sready", s_tready, 4'hF);
    check("s6_post_ack", decouple_ack, 0);
    $display("[TB] scenario reset_in_flush done");

    // Randomized traffic with channels going quiet and the request toggling.
    for (int seg = 0; seg < 40; seg++) begin
      active = NC'($urandom);
      if ($urandom_range(0, 2) == 0) decouple_req = ~decouple_req;
      for (int k = 0; k < 64; k++) begin
        for (int c = 0; c < NC; c++) begin
          s_tvalid[c] = active[c] && ($urandom_range(0, 3) != 0);
          s_tlast[c]  = ($urandom_range(0, 3) == 0);
          m_tready[c] = ($urandom_range(0, 3) != 0);
          s_tdata[c*DW +: DW] = $urandom;
          s_tkeep[c*KW +: KW] = KW'($urandom);
          s_tuser[c*UW +: UW] = UW'($urandom);
        end
        cycle();
      end
    end
    $display("[TB] scenario random_traffic done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pr_stream_decoupler.md
# pr_stream_decoupler

Packet-aware, parametrised partial-reconfiguration isolation block for NUM_CH AXI4-Stream channels crossing the static-shell/RP boundary. On a decouple request it isolates each channel only at a packet boundary, so no half-packet enters the shell or the RP. A timeout forces isolation when the RP stalls. On a forced cut it synthesises a terminating beat toward the shell, or discards the packet remainder coming from the shell. The block sits between the PCIe/DMA stream interfaces and the RP wrapper, replacing the combinational decoupler.

## Interface
- NUM_CH, 4: number of stream channels.
- DATA_W, 512: tdata width per channel.
- KEEP_W, 16: tkeep width per channel.
- USER_W, 183: tuser width per channel.
- RP_SRC_MASK, 4'b0011: bit i=1 means the RP drives channel i's upstream side; bit i=0 means the shell drives it.
- TIMEOUT_CYC, 4096: drain timeout in cycles; 0 disables the timeout.
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- decouple_req  in  1  level request to isolate the RP.
- decouple_ack  out  1  all channels isolated.
- timeout_err  out  1  sticky; the last drain was forced by the timeout.
- s_tdata/s_tkeep/s_tuser  in  NUM_CH×(DATA_W/KEEP_W/USER_W)  upstream payload, channel i at slice i.
- s_tlast, s_tvalid  in  NUM_CH  upstream control.
- s_tready  out  NUM_CH  upstream ready.
- m_tdata/m_tkeep/m_tuser  out  NUM_CH×(DATA_W/KEEP_W/USER_W)  downstream payload.
- m_tlast, m_tvalid  out  NUM_CH  downstream control.
- m_tready  in  NUM_CH  downstream ready.

## Operation
- Per-channel registers:
  - in_pkt: set on an accepted beat with tlast=0; cleared on an accepted beat with tlast=1.
  - gate
  - discard
- Ungated channel: pure combinational pass-through. m_* = s_*; s_tready = m_tready.
- Gated channel: m_tvalid=0; m_tdata/tkeep/tuser/tlast=0; s_tready=0.
- Discarding channel: s_tready=1; m_tvalid=0 and m payload 0. discard clears when an accepted beat has tlast=1.
- FSM states: COUPLED, DRAINING, FLUSH, DECOUPLED.
- COUPLED:
  - decouple_req=1 → DRAINING.
  - timeout_err cleared on this transition.
  - The drain counter loads 0.
- DRAINING:
  - At each edge, every ungated channel whose next in_pkt value is 0 sets gate.
  - All gates set → DECOUPLED.
  - Counter reaches TIMEOUT_CYC−1 with gates still open → timeout_err=1, then:
    - RP-sourced (mask=1) open channels with in_pkt=1 get pending_flush.
    - Shell-sourced (mask=0) open channels get gate=1 and discard=1.
    - Any pending_flush → FLUSH; otherwise → DECOUPLED.
  - decouple_req=0 → COUPLED. All gates clear; discard flags persist until their tlast.
- FLUSH:
  - Each pending channel drives m_tvalid=1, m_tlast=1, m_tkeep=0, m_tdata=0, m_tuser=0, s_tready=0.
  - The beat is held until m_tready=1; then that channel's pending_flush clears and gate sets.
  - All flushes done → DECOUPLED, or → COUPLED if decouple_req=0.
  - decouple_req is ignored while flushes are pending.
- DECOUPLED:
  - decouple_ack=1.
  - in_pkt forced to 0 on entry.
  - decouple_req=0 → COUPLED; gates clear at that edge.
- Counter is 32-bit and saturating.

## Timing
- Reset values: state COUPLED; all gate, discard, pending_flush and in_pkt = 0; decouple_ack=0; timeout_err=0.
- In the pass-through state, m_* equal s_* and s_tready equals m_tready in the same cycle (zero latency).
- Gating is combinational from registered gate/discard/pending_flush and takes effect the cycle after the controlling edge.
- Idle channels:
  - decouple_req is sampled high at edge 0; gates are set at edge 1.
  - decouple_ack is high from edge 2 (registered from the all-gated condition).
- A beat accepted in the same cycle its channel gates is forwarded normally; gate blocks only later beats.
- decouple_ack falls at the edge where the FSM enters COUPLED.
- Reset mid-operation: the asynchronous reset clears everything, and any in-flight packet state is lost. The downstream consumer is responsible for recovery.

## Test plan
- All channels idle, req high at cycle 0 → gate at 1, ack=1 at cycle 2; m_tvalid=0 and s_tready=0 on all channels; req low → ack=0 and pass-through at the next edge.
- Channel 0 mid-packet, with beats 2–4 of 4 left at 1 beat/cycle after req → channel 0 forwards through tlast, then gates; ack rises 2 cycles after the tlast beat; the other channels gate at cycle 1.
- TIMEOUT_CYC=16, RP channel 1 stuck mid-packet with s_tvalid=0 → at cycle 16 a flush beat appears (tvalid=1, tlast=1, tkeep=0, tdata=0) and holds under m_tready=0 for 5 cycles; after acceptance, ack=1 and timeout_err=1.
- Timeout with shell channel 2 mid-packet, 3 beats remaining → s_tready=1, m_tvalid=0 for those 3 beats; discard clears on tlast; ack=1.
- req dropped during DRAINING while channel 0 mid-packet → return to COUPLED next edge; the packet completes intact; ack never rises; timeout_err=0.
- Reset asserted asynchronously mid-FLUSH → all outputs reach their reset values immediately; after release, pass-through with ack=0 and timeout_err=0.
